// File: rtl/data_cache_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : dcc_cpu_if / dcc_mem_if
// Desc     : CPU-side word port and memory-side block port of the data cache.
// Options  : CACHE_STAT_EN adds hit_count/miss_count to the CPU port.
// Revision : 1.0 - initial release
// ============================================================================

interface dcc_cpu_if;
    logic        is_input_valid;
    logic [31:0] addr;
    logic        mem_rw;
    logic [31:0] din;
    logic        is_ready;
    logic        is_output_valid;
    logic [31:0] dout;
    logic        is_hit;
`ifdef CACHE_STAT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport slave (
        input  is_input_valid, addr, mem_rw, din,
        output is_ready, is_output_valid, dout, is_hit, hit_count, miss_count
    );
    modport master (
        output is_input_valid, addr, mem_rw, din,
        input  is_ready, is_output_valid, dout, is_hit, hit_count, miss_count
    );
`else
    modport slave (
        input  is_input_valid, addr, mem_rw, din,
        output is_ready, is_output_valid, dout, is_hit
    );
    modport master (
        output is_input_valid, addr, mem_rw, din,
        input  is_ready, is_output_valid, dout, is_hit
    );
`endif
endinterface

interface dcc_mem_if #(
    parameter int BLOCK_SIZE = 16
);
    logic                    mem_is_input_valid;
    logic [31:0]             mem_addr;
    logic                    mem_read;
    logic                    mem_write;
    logic [BLOCK_SIZE*8-1:0] mem_din;
    logic                    mem_is_output_valid;
    logic [BLOCK_SIZE*8-1:0] mem_dout;
    logic                    mem_ready;

    modport master (
        output mem_is_input_valid, mem_addr, mem_read, mem_write, mem_din,
        input  mem_is_output_valid, mem_dout, mem_ready
    );
    modport slave (
        input  mem_is_input_valid, mem_addr, mem_read, mem_write, mem_din,
        output mem_is_output_valid, mem_dout, mem_ready
    );
endinterface

`default_nettype wire

// File: rtl/data_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_controller
// Desc     : Direct-mapped, write-back, write-allocate data cache (block memory initiator).
// Options  : CACHE_STAT_EN adds saturating hit/miss request counters.
// Revision : 1.0 - initial release
// ============================================================================

module data_cache_controller #(
    parameter int NUM_SETS   = 16,
    parameter int BLOCK_SIZE = 16
) (
    input  wire logic  clk,
    input  wire logic  reset,
    dcc_cpu_if.slave   cpu,
    dcc_mem_if.master  mem
);

    localparam int c_OFF_W  = $clog2(BLOCK_SIZE);
    localparam int c_IDX_W  = $clog2(NUM_SETS);
    localparam int c_TAG_W  = 32 - c_OFF_W - c_IDX_W;
    localparam int c_WSEL_W = c_OFF_W - 2;
    localparam int c_LINE_W = BLOCK_SIZE * 8;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WB_REQ  = 3'd1;
    localparam logic [2:0] c_ST_WB_WAIT = 3'd2;
    localparam logic [2:0] c_ST_AL_REQ  = 3'd3;
    localparam logic [2:0] c_ST_AL_WAIT = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0] r_dirty;
    logic [c_TAG_W-1:0]  r_tag  [NUM_SETS];
    logic [c_LINE_W-1:0] r_data [NUM_SETS];

    logic [c_IDX_W-1:0]  w_idx;
    logic [c_TAG_W-1:0]  w_tag;
    logic [c_WSEL_W-1:0] w_wsel;
    logic [c_LINE_W-1:0] w_line;
    logic [31:0]         w_word;
    logic                w_hit;
    logic                w_wr_hit;
    logic                w_fill;
    logic                w_wb_done;
    logic                w_unused;

    assign w_idx     = cpu.addr[c_OFF_W +: c_IDX_W];
    assign w_tag     = cpu.addr[31 -: c_TAG_W];
    assign w_wsel    = cpu.addr[2 +: c_WSEL_W];
    assign w_line    = r_data[w_idx];
    assign w_word    = w_line[{w_wsel, 5'd0} +: 32];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_wr_hit  = (r_state == c_ST_IDLE) && cpu.is_input_valid && cpu.mem_rw && w_hit;
    assign w_fill    = (r_state == c_ST_AL_WAIT) && mem.mem_is_output_valid;
    assign w_wb_done = (r_state == c_ST_WB_WAIT) && mem.mem_ready;
    assign w_unused  = ^cpu.addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_hit) begin
                r_dirty[w_idx] <= 1'b1;
            end
            if (w_wb_done) begin
                r_dirty[w_idx] <= 1'b0;
            end
            if (w_fill) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end
        end
    end

    // Line payload carries no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= mem.mem_dout;
        end else if (w_wr_hit) begin
            r_data[w_idx][{w_wsel, 5'd0} +: 32] <= cpu.din;
        end
    end

    always_comb begin
        w_state_nxt            = r_state;
        cpu.is_ready           = (r_state == c_ST_IDLE);
        cpu.is_output_valid    = 1'b0;
        cpu.dout               = '0;
        cpu.is_hit             = 1'b0;
        mem.mem_is_input_valid = 1'b0;
        mem.mem_addr           = '0;
        mem.mem_read           = 1'b0;
        mem.mem_write          = 1'b0;
        mem.mem_din            = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (cpu.is_input_valid) begin
                    if (w_hit) begin
                        cpu.is_hit = 1'b1;
                        if (!cpu.mem_rw) begin
                            cpu.is_output_valid = 1'b1;
                            cpu.dout            = w_word;
                        end
                    end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                        w_state_nxt = c_ST_WB_REQ;
                    end else begin
                        w_state_nxt = c_ST_AL_REQ;
                    end
                end
            end
            c_ST_WB_REQ: begin
                if (mem.mem_ready) begin
                    mem.mem_is_input_valid = 1'b1;
                    mem.mem_write          = 1'b1;
                    mem.mem_addr           = 32'({r_tag[w_idx], w_idx});
                    mem.mem_din            = w_line;
                    w_state_nxt            = c_ST_WB_WAIT;
                end
            end
            c_ST_WB_WAIT: begin
                if (mem.mem_ready) begin
                    w_state_nxt = c_ST_AL_REQ;
                end
            end
            c_ST_AL_REQ: begin
                if (mem.mem_ready) begin
                    mem.mem_is_input_valid = 1'b1;
                    mem.mem_read           = 1'b1;
                    mem.mem_addr           = 32'(cpu.addr[31:c_OFF_W]);
                    w_state_nxt            = c_ST_AL_WAIT;
                end
            end
            c_ST_AL_WAIT: begin
                if (mem.mem_is_output_valid) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

`ifdef CACHE_STAT_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic        r_relook;
    logic        w_lookup;

    // The lookup right after a fill is a replay of the same request, not a new one.
    assign w_lookup = (r_state == c_ST_IDLE) && cpu.is_input_valid && !r_relook;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_relook     <= 1'b0;
        end else begin
            if (w_fill) begin
                r_relook <= 1'b1;
            end else if ((r_state == c_ST_IDLE) && cpu.is_input_valid) begin
                r_relook <= 1'b0;
            end
            if (w_lookup && w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_lookup && !w_hit && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign cpu.hit_count  = r_hit_count;
    assign cpu.miss_count = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache_controller
// Desc     : Directed self-checking bench for data_cache_controller with a block memory model.
// Options  : CACHE_STAT_EN enables the hit/miss counter checks.
// Revision : 1.0 - initial release
// ============================================================================

module tb_data_cache_controller;

    localparam int c_NUM_SETS   = 16;
    localparam int c_BLOCK_SIZE = 16;
    localparam int c_LINE_W     = c_BLOCK_SIZE * 8;
    localparam int c_DELAY      = 2;
    localparam int c_MEM_BLKS   = 1024;
    localparam int c_GUARD      = 100;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    dcc_cpu_if cpu_bus ();
    dcc_mem_if #(.BLOCK_SIZE(c_BLOCK_SIZE)) mem_bus ();

    data_cache_controller #(
        .NUM_SETS   (c_NUM_SETS),
        .BLOCK_SIZE (c_BLOCK_SIZE)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu_bus),
        .mem   (mem_bus)
    );

    // Block memory model: accepts a request while ready, answers DELAY+2 cycles later.
    logic [c_LINE_W-1:0] r_store [c_MEM_BLKS];
    logic                r_m_ready = 1'b1;
    logic                r_m_valid = 1'b0;
    logic [c_LINE_W-1:0] r_m_dout  = '0;
    int                  r_m_cnt   = 0;
    logic                r_m_is_rd = 1'b0;
    logic [9:0]          r_m_addr  = '0;
    int                  r_n_rd    = 0;
    int                  r_n_wr    = 0;
    int                  r_viol    = 0;
    logic [31:0]         r_last_rd_addr = '0;
    logic [31:0]         r_last_wr_addr = '0;
    logic [c_LINE_W-1:0] r_last_wr_data = '0;

    assign mem_bus.mem_ready           = r_m_ready;
    assign mem_bus.mem_is_output_valid = r_m_valid;
    assign mem_bus.mem_dout            = r_m_dout;

    function automatic logic [c_LINE_W-1:0] blk_init(input int b);
        if (b == 4) begin
            return {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        end
        return {16'(b), 16'hA0A3, 16'(b), 16'hA0A2, 16'(b), 16'hA0A1, 16'(b), 16'hA0A0};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            r_m_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_m_cnt   <= 0;
            for (int b = 0; b < c_MEM_BLKS; b++) begin
                r_store[b] <= blk_init(b);
            end
        end else begin
            r_m_valid <= 1'b0;
            if (mem_bus.mem_is_input_valid && !r_m_ready) begin
                r_viol <= r_viol + 1;
            end
            if (mem_bus.mem_is_input_valid && r_m_ready) begin
                r_m_ready <= 1'b0;
                r_m_cnt   <= c_DELAY + 1;
                r_m_is_rd <= mem_bus.mem_read;
                r_m_addr  <= mem_bus.mem_addr[9:0];
                if (mem_bus.mem_read == mem_bus.mem_write) begin
                    r_viol <= r_viol + 1;
                end
                if (mem_bus.mem_write) begin
                    r_store[mem_bus.mem_addr[9:0]] <= mem_bus.mem_din;
                    r_n_wr         <= r_n_wr + 1;
                    r_last_wr_addr <= mem_bus.mem_addr;
                    r_last_wr_data <= mem_bus.mem_din;
                end else begin
                    r_n_rd         <= r_n_rd + 1;
                    r_last_rd_addr <= mem_bus.mem_addr;
                end
            end else if (r_m_cnt != 0) begin
                r_m_cnt <= r_m_cnt - 1;
                if (r_m_cnt == 1) begin
                    r_m_ready <= 1'b1;
                    if (r_m_is_rd) begin
                        r_m_valid <= 1'b1;
                        r_m_dout  <= r_store[r_m_addr];
                    end
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request and waits for its hit cycle; returns at that cycle, before the commit edge.
    task automatic access(input logic rw, input logic [31:0] a, input logic [31:0] d,
                          output int stall, output logic first_hit);
        int guard;
        @(negedge clk);
        cpu_bus.is_input_valid = 1'b1;
        cpu_bus.addr           = a;
        cpu_bus.mem_rw         = rw;
        cpu_bus.din            = d;
        #1;
        stall     = 0;
        guard     = 0;
        first_hit = cpu_bus.is_hit;
        while (!(cpu_bus.is_ready && cpu_bus.is_hit) && (guard < c_GUARD)) begin
            @(negedge clk);
            #1;
            guard++;
            if (!cpu_bus.is_ready) begin
                stall++;
            end
        end
        check("no_timeout", 32'(guard >= c_GUARD), 32'd0);
    endtask

    task automatic idle();
        @(negedge clk);
        cpu_bus.is_input_valid = 1'b0;
        cpu_bus.mem_rw         = 1'b0;
        #1;
    endtask

    int   st;
    logic fh;
    int   rd0;
    int   wr0;
`ifdef CACHE_STAT_EN
    logic [31:0] h0;
    logic [31:0] m0;
`endif

    initial begin
        cpu_bus.is_input_valid = 1'b0;
        cpu_bus.addr           = '0;
        cpu_bus.mem_rw         = 1'b0;
        cpu_bus.din            = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready",   32'(cpu_bus.is_ready), 32'd1);
        check("rst_ovalid",  32'(cpu_bus.is_output_valid), 32'd0);
        check("rst_dout",    cpu_bus.dout, 32'd0);
        check("rst_hit",     32'(cpu_bus.is_hit), 32'd0);
        check("rst_mstrobe", 32'(mem_bus.mem_is_input_valid), 32'd0);
        check("rst_mrw",     32'({mem_bus.mem_read, mem_bus.mem_write}), 32'd0);
        check("rst_maddr",   mem_bus.mem_addr, 32'd0);
        check("rst_mdin",    32'(|mem_bus.mem_din), 32'd0);
`ifdef CACHE_STAT_EN
        check("rst_hitcnt",  cpu_bus.hit_count, 32'd0);
        check("rst_misscnt", cpu_bus.miss_count, 32'd0);
`endif
        reset = 1'b0;

        // Cold read miss on block 4
        rd0 = r_n_rd;
        wr0 = r_n_wr;
        access(1'b0, 32'h0000_0040, 32'd0, st, fh);
        check("miss_first_hit", 32'(fh), 32'd0);
        check("miss_stall",     32'(st), 32'(c_DELAY + 3));
        check("miss_dout",      cpu_bus.dout, 32'hAAAA_AAAA);
        check("miss_ovalid",    32'(cpu_bus.is_output_valid), 32'd1);
        check("miss_nrd",       32'(r_n_rd - rd0), 32'd1);
        check("miss_rdaddr",    r_last_rd_addr, 32'h0000_0004);

        // Same-line read hit
        access(1'b0, 32'h0000_0044, 32'd0, st, fh);
        check("hit_first",  32'(fh), 32'd1);
        check("hit_stall",  32'(st), 32'd0);
        check("hit_dout",   cpu_bus.dout, 32'hBBBB_BBBB);
        check("hit_nrd",    32'(r_n_rd - rd0), 32'd1);

        // Write hit, then read it back
        access(1'b1, 32'h0000_0048, 32'h1234_5678, st, fh);
        check("wr_first",  32'(fh), 32'd1);
        check("wr_stall",  32'(st), 32'd0);
        check("wr_ovalid", 32'(cpu_bus.is_output_valid), 32'd0);
        check("wr_dout",   cpu_bus.dout, 32'd0);
        access(1'b0, 32'h0000_0048, 32'd0, st, fh);
        check("wr_rdback", cpu_bus.dout, 32'h1234_5678);

        // Conflict on a dirty line: write-back of block 4, then fill of block 0x104
        access(1'b0, 32'h0000_1048, 32'd0, st, fh);
        check("wb_first_hit", 32'(fh), 32'd0);
        check("wb_stall",     32'(st), 32'(2 * (c_DELAY + 3)));
        check("wb_nwr",       32'(r_n_wr - wr0), 32'd1);
        check("wb_addr",      r_last_wr_addr, 32'h0000_0004);
        check("wb_word2",     r_last_wr_data[95:64], 32'h1234_5678);
        check("wb_word0",     r_last_wr_data[31:0], 32'hAAAA_AAAA);
        check("wb_nrd",       32'(r_n_rd - rd0), 32'd2);
        check("wb_rdaddr",    r_last_rd_addr, 32'h0000_0104);
        check("wb_dout",      cpu_bus.dout, 32'h0104_A0A2);

        // Conflict on a clean line: no write-back
        rd0 = r_n_rd;
        access(1'b0, 32'h0000_0080, 32'd0, st, fh);
        check("cl_dout0", cpu_bus.dout, 32'h0008_A0A0);
        access(1'b0, 32'h0000_1080, 32'd0, st, fh);
        check("cl_stall",  32'(st), 32'(c_DELAY + 3));
        check("cl_nwr",    32'(r_n_wr - wr0), 32'd1);
        check("cl_nrd",    32'(r_n_rd - rd0), 32'd2);
        check("cl_rdaddr", r_last_rd_addr, 32'h0000_0108);
        check("cl_dout1",  cpu_bus.dout, 32'h0108_A0A0);

        // hit, miss, hit, miss
`ifdef CACHE_STAT_EN
        h0 = cpu_bus.hit_count;
        m0 = cpu_bus.miss_count;
`endif
        access(1'b0, 32'h0000_1084, 32'd0, st, fh);
        check("seq1_hit", 32'(fh), 32'd1);
        access(1'b0, 32'h0000_2080, 32'd0, st, fh);
        check("seq2_hit", 32'(fh), 32'd0);
        access(1'b0, 32'h0000_2084, 32'd0, st, fh);
        check("seq3_dout", cpu_bus.dout, 32'h0208_A0A1);
        access(1'b0, 32'h0000_0040, 32'd0, st, fh);
        check("seq4_hit", 32'(fh), 32'd0);
        idle();
`ifdef CACHE_STAT_EN
        check("stat_hits",   cpu_bus.hit_count - h0, 32'd2);
        check("stat_misses", cpu_bus.miss_count - m0, 32'd2);
`endif

        // Reset while waiting for fill data
        @(negedge clk);
        cpu_bus.is_input_valid = 1'b1;
        cpu_bus.addr           = 32'h0000_2040;
        cpu_bus.mem_rw         = 1'b0;
        #1;
        check("ar_miss", 32'(cpu_bus.is_hit), 32'd0);
        @(negedge clk);
        #1;
        check("ar_req_read", 32'({mem_bus.mem_is_input_valid, mem_bus.mem_read}), 32'd3);
        check("ar_req_addr", mem_bus.mem_addr, 32'h0000_0204);
        @(negedge clk);
        reset                  = 1'b1;
        cpu_bus.is_input_valid = 1'b0;
        @(negedge clk);
        #1;
        check("ar_ready",   32'(cpu_bus.is_ready), 32'd1);
        check("ar_mstrobe", 32'(mem_bus.mem_is_input_valid), 32'd0);
        check("ar_mrw",     32'({mem_bus.mem_read, mem_bus.mem_write}), 32'd0);
        check("ar_maddr",   mem_bus.mem_addr, 32'd0);
        check("ar_mdin",    32'(|mem_bus.mem_din), 32'd0);
        reset = 1'b0;
        access(1'b0, 32'h0000_2040, 32'd0, st, fh);
        check("ar_rehit",  32'(fh), 32'd0);
        check("ar_stall",  32'(st), 32'(c_DELAY + 3));
        check("ar_dout",   cpu_bus.dout, 32'h0204_A0A0);
        idle();

        check("mem_protocol", 32'(r_viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_cache_controller.md
Name: data_cache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache. It is the initiator that drives the block-granular data memory's request/ready/valid handshake.
- Sits between the pipeline MEM stage (word requests) and the data memory (whole-block requests).
- Hides memory latency on hits. Stalls the pipeline through `is_ready` on misses.

Parameters:
- NUM_SETS, 16, number of cache lines; power of two, at least 2.
- BLOCK_SIZE, 16, bytes per line; must match the data memory's BLOCK_SIZE.
- Word fields: words per line = BLOCK_SIZE/4; offset bits = log2(BLOCK_SIZE); index bits = log2(NUM_SETS).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- is_input_valid  in  1  CPU request valid.
- addr  in  32  CPU byte address; bits [1:0] ignored.
- mem_rw  in  1  0 = read, 1 = write.
- din  in  32  CPU write word.
- is_ready  out  1  cache can accept a new request (state IDLE).
- is_output_valid  out  1  read data on dout is valid this cycle.
- dout  out  32  read word; 0 when not valid.
- is_hit  out  1  current request hits a valid line with matching tag.
- mem_is_input_valid  out  1  memory request strobe.
- mem_addr  out  32  block address = byte address >> log2(BLOCK_SIZE).
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_din  out  BLOCK_SIZE*8  block to write back.
- mem_is_output_valid  in  1  memory read data valid.
- mem_dout  in  BLOCK_SIZE*8  memory read block.
- mem_ready  in  1  memory idle and able to accept a request.

Behaviour:
- Address split: offset = addr[log2(BLOCK_SIZE)-1:0], with word select = offset[..:2]; index = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Per line: valid bit, dirty bit, tag, BLOCK_SIZE*8 data.
- Reset: all valid and dirty bits cleared; state IDLE.
- Reset output values: is_ready=1; is_output_valid=0, dout=0, is_hit=0; all mem_* outputs 0.
- Reset mid-miss abandons the transaction. The memory shares the same reset.
- States: IDLE, WB_REQ, WB_WAIT, AL_REQ, AL_WAIT.
- IDLE, combinational lookup on the request:
  - Read hit: is_hit=1, is_output_valid=1, dout = selected word, all in the same cycle. Zero-cycle latency.
  - Write hit: word written at the clock edge; dirty set; is_hit=1; is_output_valid=0.
  - Miss with line valid and dirty: go to WB_REQ.
  - Miss otherwise: go to AL_REQ.
  - No request: stay in IDLE.
- WB_REQ:
  - While mem_ready=1: assert mem_is_input_valid=1, mem_write=1, mem_addr = {stored tag, index}, mem_din = line data. Go to WB_WAIT the next cycle.
  - If mem_ready=0: hold in WB_REQ with the strobe deasserted.
- WB_WAIT: when mem_ready returns to 1, clear dirty and go to AL_REQ.
- AL_REQ: same issue rule as WB_REQ, with mem_read=1 and mem_addr = request block address. Go to AL_WAIT.
- AL_WAIT: on mem_is_output_valid=1, latch mem_dout into the line; set valid and tag; clear dirty; return to IDLE.
  - The held request is then re-looked-up and hits. Fill and CPU write are never merged.
- mem_* request signals are 1 for exactly one cycle per request, and only when mem_ready=1.
- CPU must hold addr, mem_rw and din stable while is_ready=0.
- is_hit is asserted only in IDLE. Requests with is_input_valid=0 never alter state.
- Memory DELAY must be at least 1. Miss latency (clean) = DELAY+3 cycles to the hit cycle.

Optional Feature:
- Macro: CACHE_STAT_EN.
- When defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - Each counts requests at their first IDLE lookup only; the post-fill re-lookup is not counted.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then read addr 0x0000_0040 (memory block 4 = 0x...DDDDCCCCBBBBAAAA), DELAY=2 → one read request with mem_addr=4; is_ready low 5 cycles; then is_hit=1, dout=0xAAAAAAAA.
- Read 0x44 right after → same-cycle hit; dout=0xBBBBBBBB; no memory request.
- Write 0x48 din=0x12345678, then read 0x1048 (same index 4, different tag) → write-back with mem_addr=4, word2=0x12345678, then read with mem_addr=0x104. No other memory traffic.
- Read a clean line, then a conflicting address → no write-back; only one memory read.
- Assert reset during AL_WAIT → next cycle is_ready=1, all mem_* outputs 0; a read of the same address misses again.
- With CACHE_STAT_EN: the 4-access sequence hit, miss, hit, miss → hit_count=2, miss_count=2.
